regfile_wb_arbiter: RTL and testbench

Write-port arbiter and reservation scoreboard for the 32×32 register file. It shares the file's single write port between two writers: the pipeline writeback stage and the multi-cycle mult/div unit. It registers the winning write onto the file's write controls. It also tracks which destination registers have an outstanding mult/div result, so the hazard logic can stall readers.

---
 rtl/regfile_pkg.sv | 30 +++
 rtl/regfile_scoreboard.sv | 35 +++
 rtl/regfile_wb_arbiter.sv | 151 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Optional feature macro used by the arbiter: ARB_STARVE_GUARD_EN.
package regfile_pkg;

  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  // Identifies which writer owns the write port in a given cycle.
  typedef enum logic [0:0] {
    REQ_WB = 1'b0,
    REQ_MD = 1'b1
  } req_idx_e;

  // One-hot register select; register 0 never maps to a bit.
  function automatic logic [REG_COUNT-1:0] reg_onehot(
    input logic                  en,
    input logic [REG_ADDR_W-1:0] r
  );
    logic [REG_COUNT-1:0] m;
    m = {REG_COUNT{1'b0}};
    if (en && (r != {REG_ADDR_W{1'b0}})) begin
      m[r] = 1'b1;
    end else begin
      m = {REG_COUNT{1'b0}};
    end
    return m;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy bits for registers awaiting a mult/div result. A reservation
// and a completion hitting the same register in one cycle leave it busy,
// so a back-to-back reservation is never lost.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_reg,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_reg,
  output logic [REG_COUNT-1:0]  busy_mask
);

  logic [REG_COUNT-1:0] busy_d;
  logic [REG_COUNT-1:0] busy_q;

  // Next busy state: clear first, then set, so the set wins a collision.
  always_comb begin
    busy_d = (busy_q & ~reg_onehot(clr_en, clr_reg)) | reg_onehot(set_en, set_reg);
  end

  // Busy register with synchronous reset.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      busy_q <= {REG_COUNT{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_mask = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between pipeline writeback and the
// mult/div unit, registers the winning write, and tracks outstanding
// mult/div destinations. Define ARB_STARVE_GUARD_EN to force the mult/div
// writer through after STARVE_MAX consecutive refusals.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]     wb_data,
  output logic                  wb_ready,
  input  logic                  md_valid,
  input  logic [REG_ADDR_W-1:0] md_reg,
  input  logic [DATA_W-1:0]     md_data,
  output logic                  md_ready,
  input  logic                  rsv_valid,
  input  logic [REG_ADDR_W-1:0] rsv_reg,
  output logic [REG_COUNT-1:0]  busy_mask,
  output logic                  ctrl_writeEnable,
  output logic [REG_ADDR_W-1:0] ctrl_writeReg,
  output logic [DATA_W-1:0]     data_writeReg
);

  if ((STARVE_MAX < 1) || (STARVE_MAX > 15)) begin : g_bad_starve_max
    $error("STARVE_MAX must lie in 1..15");
  end

  logic                  force_md_s;
  logic                  wb_ready_s;
  logic                  md_ready_s;
  logic                  grant_s;
  req_idx_e              winner_s;
  logic                  we_d, we_q;
  logic [REG_ADDR_W-1:0] wreg_d, wreg_q;
  logic [DATA_W-1:0]     wdata_d, wdata_q;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  logic [3:0] starve_d;
  logic [3:0] starve_q;

  // Mult/div is forced through once it has been refused STARVE_MAX times in a row.
  always_comb begin
    force_md_s = (starve_q == STARVE_LIMIT);
  end

  // Run length of refused mult/div cycles, saturating at the limit.
  always_comb begin
    if (md_valid && !md_ready_s) begin
      if (starve_q == STARVE_LIMIT) begin
        starve_d = starve_q;
      end else begin
        starve_d = starve_q + 4'd1;
      end
    end else begin
      starve_d = 4'd0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // Strict pipeline priority: mult/div is never forced.
  always_comb begin
    force_md_s = 1'b0;
  end
`endif

  // Combinational grant: pipeline first unless mult/div is being forced.
  always_comb begin
    wb_ready_s = wb_valid & ~force_md_s;
    md_ready_s = md_valid & (~wb_valid | force_md_s);
    grant_s    = wb_ready_s | md_ready_s;
    if (wb_ready_s) begin
      winner_s = REQ_WB;
    end else begin
      winner_s = REQ_MD;
    end
  end

  assign wb_ready = wb_ready_s;
  assign md_ready = md_ready_s;

  // Capture the winner's write; address and data hold when nobody is granted.
  always_comb begin
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (grant_s) begin
      case (winner_s)
        REQ_WB: begin
          we_d    = (wb_reg != 5'd0);
          wreg_d  = wb_reg;
          wdata_d = wb_data;
        end
        REQ_MD: begin
          we_d    = (md_reg != 5'd0);
          wreg_d  = md_reg;
          wdata_d = md_data;
        end
        default: begin
          we_d    = 1'b0;
          wreg_d  = wreg_q;
          wdata_d = wdata_q;
        end
      endcase
    end else begin
      we_d = 1'b0;
    end
  end

  // Write-port output register; reset drops any captured write.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      we_q    <= 1'b0;
      wreg_q  <= {REG_ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
    end else begin
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;

  // Clearing on the md grant edge makes the bit drop as the write lands.
  regfile_scoreboard u_scoreboard (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .set_en     (rsv_valid),
    .set_reg    (rsv_reg),
    .clr_en     (md_ready_s),
    .clr_reg    (md_reg),
    .busy_mask  (busy_mask)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized self-checking bench for regfile_wb_arbiter against a
// behavioural model of the arbitration and scoreboard rules.
module tb_regfile_wb_arbiter;

  localparam int STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clock;
  logic        ctrl_reset;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_ready;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready;
  logic        rsv_valid;
  logic [4:0]  rsv_reg;
  logic [31:0] busy_mask;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  regfile_wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .wb_valid         (wb_valid),
    .wb_reg           (wb_reg),
    .wb_data          (wb_data),
    .wb_ready         (wb_ready),
    .md_valid         (md_valid),
    .md_reg           (md_reg),
    .md_data          (md_data),
    .md_ready         (md_ready),
    .rsv_valid        (rsv_valid),
    .rsv_reg          (rsv_reg),
    .busy_mask        (busy_mask),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks_total  = 0;
  int checks_passed = 0;
  int md_grants     = 0;

  // Reference model state
  bit          m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  bit          m_busy [32];
  int          m_refused;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end else begin
      checks_passed++;
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    for (int i = 0; i < 32; i++) m[i] = m_busy[i];
    return m;
  endfunction

  task automatic run_cycle(input bit rst, input bit wv, input logic [4:0] wr, input logic [31:0] wd,
                           input bit mv, input logic [4:0] mr, input logic [31:0] md,
                           input bit rv, input logic [4:0] rr);
    bit force_md, e_wr, e_mr;
    ctrl_reset = rst; wb_valid = wv; wb_reg = wr; wb_data = wd;
    md_valid = mv; md_reg = mr; md_data = md; rsv_valid = rv; rsv_reg = rr;
    #4;
    force_md = GUARD && mv && (m_refused == STARVE_MAX);
    e_wr = wv && !force_md;
    e_mr = mv && (!wv || force_md);
    check_eq("wb_ready", {31'd0, wb_ready}, {31'd0, e_wr});
    check_eq("md_ready", {31'd0, md_ready}, {31'd0, e_mr});
    check_eq("write_enable", {31'd0, ctrl_writeEnable}, {31'd0, m_we});
    check_eq("write_reg", {27'd0, ctrl_writeReg}, {27'd0, m_reg});
    check_eq("write_data", data_writeReg, m_data);
    check_eq("busy_mask", busy_mask, model_mask());
    @(posedge clock);
    if (rst) begin
      m_we = 1'b0; m_reg = 5'd0; m_data = 32'd0; m_refused = 0;
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (e_wr) begin
        m_we = (wr != 5'd0); m_reg = wr; m_data = wd;
      end else if (e_mr) begin
        m_we = (mr != 5'd0); m_reg = mr; m_data = md;
      end else begin
        m_we = 1'b0;
      end
      if (e_mr) begin
        m_busy[mr] = 1'b0;
        md_grants++;
      end
      if (rv && rr != 5'd0) m_busy[rr] = 1'b1;
      if (mv && !e_mr) m_refused = (m_refused + 1 > STARVE_MAX) ? STARVE_MAX : m_refused + 1;
      else m_refused = 0;
    end
    #1;
  endtask

  task automatic idle();
    run_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  initial begin
    int grants_before;
    ctrl_reset = 1'b1; wb_valid = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
    md_valid = 1'b0; md_reg = 5'd0; md_data = 32'd0; rsv_valid = 1'b0; rsv_reg = 5'd0;
    m_we = 1'b0; m_reg = 5'd0; m_data = 32'd0; m_refused = 0;
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    @(posedge clock); #1;
    run_cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

    // Basic pipeline write
    run_cycle(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    idle();
    // Contention, then mult/div alone
    run_cycle(1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0);
    run_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0);
    idle();
    // Register 0 write from mult/div
    run_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0);
    idle();
    // Scoreboard set, clear, and simultaneous set/clear
    run_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    idle();
    run_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
    idle();
    run_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h78, 1'b1, 5'd7);
    idle();
    // Starvation: both writers held high
    grants_before = md_grants;
    for (int i = 0; i < 7; i++)
      run_cycle(1'b0, 1'b1, 5'd1, 32'h100 + i, 1'b1, 5'd2, 32'h200 + i, 1'b0, 5'd0);
    check_eq("starve_md_grants", md_grants - grants_before, GUARD ? 32'd1 : 32'd0);
    idle();
    // Mid-operation reset with a reservation outstanding
    run_cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12);
    run_cycle(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    idle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      run_cycle(($urandom_range(0, 49) == 0),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
